// File: rtl/regfile_scoreboard.sv
// Integer register file with a per-register busy scoreboard for in-order issue.
// Tracks outstanding writes, gates issue on RAW/WAW hazards and forwards same-cycle writeback.
module regfile_scoreboard #(
    parameter int               XLEN    = 32,
    parameter int               NREG    = 32,
    parameter int               SP_IDX  = 2,
    parameter logic [XLEN-1:0]  SP_INIT = 32'h0001_0000,
    parameter int               BYPASS  = 1,
    localparam int              AW      = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            iss_valid,
    input  logic            iss_we,
    input  logic [AW-1:0]   iss_rd,
    input  logic [AW-1:0]   iss_rs1,
    input  logic [AW-1:0]   iss_rs2,
    output logic            iss_ready,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,

    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,

    input  logic            flush,
    output logic [NREG-1:0] busy_vec,
    output logic [AW:0]     pend_cnt,
    output logic            err_wb
);

    localparam bit BYP = (BYPASS != 0);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [AW:0]     cnt_q;
    logic [AW:0]     cnt_d;
    logic            err_q;

    logic            wb_hit;
    logic            fwd1;
    logic            fwd2;
    logic            rs1_clear;
    logic            rs2_clear;
    logic            rd_clear;
    logic            fire;

    function automatic logic [AW:0] popcount(input logic [NREG-1:0] v);
        logic [AW:0] c;
        c = '0;
        for (int i = 0; i < NREG; i++) begin
            c = c + {{AW{1'b0}}, v[i]};
        end
        return c;
    endfunction

    // Register 0 is never a writeback target, so it is excluded up front.
    assign wb_hit = wb_valid && (wb_rd != '0);

    assign fwd1 = BYP && wb_hit && (wb_rd == iss_rs1);
    assign fwd2 = BYP && wb_hit && (wb_rd == iss_rs2);

    assign rs1_data = (iss_rs1 == '0) ? '0 : (fwd1 ? wb_data : regs[iss_rs1]);
    assign rs2_data = (iss_rs2 == '0) ? '0 : (fwd2 ? wb_data : regs[iss_rs2]);

    // A busy register counts as clear when its result is landing this very cycle.
    assign rs1_clear = (iss_rs1 == '0) || !busy_q[iss_rs1] || fwd1;
    assign rs2_clear = (iss_rs2 == '0) || !busy_q[iss_rs2] || fwd2;
    assign rd_clear  = !iss_we || (iss_rd == '0) || !busy_q[iss_rd]
                     || (BYP && wb_hit && (wb_rd == iss_rd));

    assign iss_ready = rs1_clear && rs2_clear && rd_clear && !flush;
    assign fire      = iss_valid && iss_ready;

    // NOTE: every signal assigned in always_comb gets a default first; a missed path infers a latch.
    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end else begin
            if (wb_hit) begin
                busy_d[wb_rd] = 1'b0;
            end
            // Ordered after the clear so a same-index issue keeps the register busy.
            if (fire && iss_we && (iss_rd != '0)) begin
                busy_d[iss_rd] = 1'b1;
            end
        end
        cnt_d = popcount(busy_d);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            if (wb_hit && !busy_q[wb_rd]) begin
                err_q <= 1'b1;
            end
        end
    end

    // NOTE: the array is reset deliberately because the stack pointer needs a defined start value.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= (i == SP_IDX) ? SP_INIT : '0;
            end
        end else if (wb_hit) begin
            regs[wb_rd] <= wb_data;
        end
    end

    assign busy_vec = busy_q;
    assign pend_cnt = cnt_q;
    assign err_wb   = err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: reset state, RAW/WAW hazards with bypass,
// set-over-clear collision, register 0, flush with stray writeback, and reset override.
module tb_regfile_scoreboard;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam logic [XLEN-1:0] SP_INIT = 32'h0001_0000;

    logic            clk;
    logic            rst;
    logic            iss_valid;
    logic            iss_we;
    logic [AW-1:0]   iss_rd;
    logic [AW-1:0]   iss_rs1;
    logic [AW-1:0]   iss_rs2;
    logic            iss_ready;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            wb_valid;
    logic [AW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            flush;
    logic [NREG-1:0] busy_vec;
    logic [AW:0]     pend_cnt;
    logic            err_wb;

    int checks;
    int failures;

    regfile_scoreboard #(
        .XLEN    (XLEN),
        .NREG    (NREG),
        .SP_IDX  (2),
        .SP_INIT (SP_INIT),
        .BYPASS  (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .iss_valid (iss_valid),
        .iss_we    (iss_we),
        .iss_rd    (iss_rd),
        .iss_rs1   (iss_rs1),
        .iss_rs2   (iss_rs2),
        .iss_ready (iss_ready),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .flush     (flush),
        .busy_vec  (busy_vec),
        .pend_cnt  (pend_cnt),
        .err_wb    (err_wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs are then changed away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        iss_valid = 1'b0;
        iss_we    = 1'b0;
        iss_rd    = '0;
        iss_rs1   = '0;
        iss_rs2   = '0;
        wb_valid  = 1'b0;
        wb_rd     = '0;
        wb_data   = '0;
        flush     = 1'b0;
    endtask

    task automatic issue_one(input logic [AW-1:0] rd);
        idle();
        iss_valid = 1'b1;
        iss_we    = 1'b1;
        iss_rd    = rd;
        tick();
        idle();
        #1;
    endtask

    task automatic test_reset();
        idle();
        iss_rs1 = 5'd2;
        iss_rs2 = 5'd5;
        iss_we  = 1'b1;
        iss_rd  = 5'd31;
        #1;
        checks++;
        if (rs1_data !== SP_INIT) begin
            failures++;
            $display("FAIL reset_sp got=%h exp=%h", rs1_data, SP_INIT);
        end
        checks++;
        if (rs2_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_r5 got=%h exp=%h", rs2_data, 32'h0);
        end
        checks++;
        if (busy_vec !== 32'h0) begin
            failures++;
            $display("FAIL reset_busy got=%h exp=%h", busy_vec, 32'h0);
        end
        checks++;
        if (pend_cnt !== 6'd0) begin
            failures++;
            $display("FAIL reset_pend got=%0d exp=0", pend_cnt);
        end
        checks++;
        if (err_wb !== 1'b0) begin
            failures++;
            $display("FAIL reset_err got=%b exp=0", err_wb);
        end
        checks++;
        if (iss_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%b exp=1", iss_ready);
        end
    endtask

    task automatic test_hazard_bypass();
        issue_one(5'd5);
        checks++;
        if (busy_vec !== 32'h0000_0020 || pend_cnt !== 6'd1) begin
            failures++;
            $display("FAIL haz_busy got=%h/%0d exp=00000020/1", busy_vec, pend_cnt);
        end
        // RAW on rs1
        iss_rs1 = 5'd5;
        #1;
        checks++;
        if (iss_ready !== 1'b0) begin
            failures++;
            $display("FAIL haz_raw_ready got=%b exp=0", iss_ready);
        end
        // WAW on rd
        iss_rs1 = 5'd0;
        iss_we  = 1'b1;
        iss_rd  = 5'd5;
        #1;
        checks++;
        if (iss_ready !== 1'b0) begin
            failures++;
            $display("FAIL haz_waw_ready got=%b exp=0", iss_ready);
        end
        iss_we   = 1'b0;
        iss_rd   = 5'd0;
        iss_rs1  = 5'd5;
        iss_rs2  = 5'd5;
        wb_valid = 1'b1;
        wb_rd    = 5'd5;
        wb_data  = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (iss_ready !== 1'b1) begin
            failures++;
            $display("FAIL haz_bypass_ready got=%b exp=1", iss_ready);
        end
        checks++;
        if (rs1_data !== 32'hDEAD_BEEF || rs2_data !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL haz_bypass_data got=%h/%h exp=deadbeef", rs1_data, rs2_data);
        end
        tick();
        wb_valid = 1'b0;
        wb_data  = '0;
        #1;
        checks++;
        if (busy_vec !== 32'h0 || pend_cnt !== 6'd0) begin
            failures++;
            $display("FAIL haz_release got=%h/%0d exp=00000000/0", busy_vec, pend_cnt);
        end
        checks++;
        if (rs1_data !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL haz_regread got=%h exp=deadbeef", rs1_data);
        end
        checks++;
        if (err_wb !== 1'b0) begin
            failures++;
            $display("FAIL haz_err got=%b exp=0", err_wb);
        end
    endtask

    task automatic test_same_cycle();
        issue_one(5'd7);
        iss_valid = 1'b1;
        iss_we    = 1'b1;
        iss_rd    = 5'd7;
        wb_valid  = 1'b1;
        wb_rd     = 5'd7;
        wb_data   = 32'h7777_0007;
        #1;
        checks++;
        if (iss_ready !== 1'b1) begin
            failures++;
            $display("FAIL same_ready got=%b exp=1", iss_ready);
        end
        tick();
        idle();
        iss_rs1 = 5'd7;
        #1;
        checks++;
        if (busy_vec !== 32'h0000_0080 || pend_cnt !== 6'd1) begin
            failures++;
            $display("FAIL same_busy got=%h/%0d exp=00000080/1", busy_vec, pend_cnt);
        end
        checks++;
        if (rs1_data !== 32'h7777_0007) begin
            failures++;
            $display("FAIL same_data got=%h exp=77770007", rs1_data);
        end
        checks++;
        if (err_wb !== 1'b0) begin
            failures++;
            $display("FAIL same_err got=%b exp=0", err_wb);
        end
        wb_valid = 1'b1;
        wb_rd    = 5'd7;
        wb_data  = 32'h7777_0008;
        tick();
        idle();
        #1;
        checks++;
        if (busy_vec !== 32'h0 || pend_cnt !== 6'd0) begin
            failures++;
            $display("FAIL same_release got=%h/%0d exp=00000000/0", busy_vec, pend_cnt);
        end
    endtask

    task automatic test_reg0();
        iss_valid = 1'b1;
        iss_we    = 1'b1;
        iss_rd    = 5'd0;
        wb_valid  = 1'b1;
        wb_rd     = 5'd0;
        wb_data   = 32'h0000_1234;
        #1;
        checks++;
        if (rs1_data !== 32'h0 || iss_ready !== 1'b1) begin
            failures++;
            $display("FAIL r0_comb got=%h/%b exp=00000000/1", rs1_data, iss_ready);
        end
        tick();
        idle();
        #1;
        checks++;
        if (busy_vec !== 32'h0 || pend_cnt !== 6'd0) begin
            failures++;
            $display("FAIL r0_busy got=%h/%0d exp=00000000/0", busy_vec, pend_cnt);
        end
        checks++;
        if (rs1_data !== 32'h0 || err_wb !== 1'b0) begin
            failures++;
            $display("FAIL r0_state got=%h/%b exp=00000000/0", rs1_data, err_wb);
        end
    endtask

    task automatic test_flush();
        issue_one(5'd3);
        issue_one(5'd4);
        issue_one(5'd6);
        checks++;
        if (busy_vec !== 32'h0000_0058 || pend_cnt !== 6'd3) begin
            failures++;
            $display("FAIL flush_pre got=%h/%0d exp=00000058/3", busy_vec, pend_cnt);
        end
        flush     = 1'b1;
        iss_valid = 1'b1;
        iss_we    = 1'b1;
        iss_rd    = 5'd9;
        #1;
        checks++;
        if (iss_ready !== 1'b0) begin
            failures++;
            $display("FAIL flush_ready got=%b exp=0", iss_ready);
        end
        tick();
        idle();
        #1;
        checks++;
        if (busy_vec !== 32'h0 || pend_cnt !== 6'd0 || err_wb !== 1'b0) begin
            failures++;
            $display("FAIL flush_clear got=%h/%0d/%b exp=00000000/0/0", busy_vec, pend_cnt, err_wb);
        end
        wb_valid = 1'b1;
        wb_rd    = 5'd3;
        wb_data  = 32'h0000_3333;
        tick();
        idle();
        iss_rs1 = 5'd3;
        #1;
        checks++;
        if (err_wb !== 1'b1) begin
            failures++;
            $display("FAIL flush_err got=%b exp=1", err_wb);
        end
        checks++;
        if (rs1_data !== 32'h0000_3333) begin
            failures++;
            $display("FAIL flush_wbdata got=%h exp=00003333", rs1_data);
        end
        tick();
        #1;
        checks++;
        if (err_wb !== 1'b1) begin
            failures++;
            $display("FAIL flush_sticky got=%b exp=1", err_wb);
        end
    endtask

    task automatic test_reset_override();
        issue_one(5'd10);
        issue_one(5'd11);
        issue_one(5'd12);
        checks++;
        if (pend_cnt !== 6'd3) begin
            failures++;
            $display("FAIL rst_pre got=%0d exp=3", pend_cnt);
        end
        rst       = 1'b0;
        wb_valid  = 1'b1;
        wb_rd     = 5'd2;
        wb_data   = 32'hFFFF_FFFF;
        iss_valid = 1'b1;
        iss_we    = 1'b1;
        iss_rd    = 5'd13;
        tick();
        rst = 1'b1;
        idle();
        iss_rs1 = 5'd2;
        iss_rs2 = 5'd3;
        #1;
        checks++;
        if (busy_vec !== 32'h0 || pend_cnt !== 6'd0 || err_wb !== 1'b0) begin
            failures++;
            $display("FAIL rst_state got=%h/%0d/%b exp=00000000/0/0", busy_vec, pend_cnt, err_wb);
        end
        checks++;
        if (rs1_data !== SP_INIT || rs2_data !== 32'h0) begin
            failures++;
            $display("FAIL rst_regs got=%h/%h exp=%h/00000000", rs1_data, rs2_data, SP_INIT);
        end
        checks++;
        if (iss_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_ready got=%b exp=1", iss_ready);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        idle();
        tick();
        tick();
        rst = 1'b1;
        test_reset();
        test_hazard_bypass();
        test_same_cycle();
        test_reg0();
        test_flush();
        test_reset_override();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
